// File: rtl/vga_driver.sv
// vga_driver: VGA timing generator with registered sync, RGB and frame tick.
// Build option: define VGA_TEST_PATTERN_EN to show eight vertical color bars.
module vga_driver #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        CLOCK_25,
    input  logic        RESET_N,
    input  logic [2:0]  color,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_R,
    output logic        VGA_G,
    output logic        VGA_B,
    output logic        frame_tick
);

    localparam logic [11:0] H_LAST =
        12'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [11:0] V_LAST =
        12'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [11:0] H_VIS    = 12'(H_VISIBLE);
    localparam logic [11:0] V_VIS    = 12'(V_VISIBLE);
    localparam logic [11:0] HS_START = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] HS_END   = 12'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [11:0] VS_START = 12'(V_VISIBLE + V_FRONT);
    localparam logic [11:0] VS_END   = 12'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        h_wrap;
    logic        v_wrap;
    logic        visible;
    logic        hs_act;
    logic        vs_act;
    logic        blank_start;
    logic [2:0]  pix;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // Pixel and line counters; lines advance only when a line wraps.
    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? 12'd0 : v_cnt + 12'd1;
            end else begin
                h_cnt <= h_cnt + 12'd1;
            end
        end
    end

    // Visible-area decode and 1-based coordinates for the pixel source.
    always_comb begin
        visible     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_act      = (h_cnt >= HS_START) && (h_cnt <= HS_END);
        vs_act      = (v_cnt >= VS_START) && (v_cnt <= VS_END);
        blank_start = (h_cnt == 12'd0) && (v_cnt == V_VIS);
        x           = visible ? h_cnt + 12'd1 : 12'd0;
        y           = visible ? v_cnt + 12'd1 : 12'd0;
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [11:0] BAR_W = 12'(H_VISIBLE / 8);
    logic unused_color;
    assign unused_color = ^color;
    // Bar index is the column divided by the bar width (x-1 == h_cnt).
    always_comb begin
        pix = 3'(h_cnt / BAR_W);
    end
`else
    // Pixel color comes straight from the external source.
    always_comb begin
        pix = color;
    end
`endif

    // Output stage: sync, color and tick share one register delay.
    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            VGA_HS     <= 1'b1;
            VGA_VS     <= 1'b1;
            VGA_R      <= 1'b0;
            VGA_G      <= 1'b0;
            VGA_B      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            VGA_HS     <= ~hs_act;
            VGA_VS     <= ~vs_act;
            VGA_R      <= visible & pix[2];
            VGA_G      <= visible & pix[1];
            VGA_B      <= visible & pix[0];
            frame_tick <= blank_start;
        end
    end

endmodule
